// File: rtl/led_pattern_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : led_pattern_seq                                                  |
// | Purpose : Animated LED pattern driver stepped by a slow divided clock.     |
// |           step_in is synchronised into CLK100MHZ and edge-detected; each   |
// |           rising edge advances the selected pattern by one step.           |
// | Ports   : CLK100MHZ  - system clock                                        |
// |           CPU_RESETN - synchronous active-low reset                        |
// |           step_in    - asynchronous step level (rising edge = one step)    |
// |           mode       - 0 COUNT, 1 BOUNCE, 2 BAR, 3 BREATHE                 |
// |           run        - 1 advance on steps, 0 freeze                        |
// |           LED        - registered LED drive                                |
// |           wrap       - one-cycle pulse when a step returns val to 0        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module led_pattern_seq #(
  parameter int WIDTH    = 7,
  parameter int PWM_BITS = 8
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic             step_in,
  input  logic [1:0]       mode,
  input  logic             run,
  output logic [WIDTH-1:0] LED,
  output logic             wrap
);

  // val must hold a full COUNT value (WIDTH bits) and a full BREATHE duty.
  localparam int c_VW = (WIDTH > PWM_BITS) ? WIDTH : PWM_BITS;

  localparam logic [1:0] c_MODE_COUNT   = 2'd0;
  localparam logic [1:0] c_MODE_BOUNCE  = 2'd1;
  localparam logic [1:0] c_MODE_BAR     = 2'd2;
  localparam logic [1:0] c_MODE_BREATHE = 2'd3;

  localparam logic c_DIR_UP   = 1'b0;
  localparam logic c_DIR_DOWN = 1'b1;

  localparam logic [c_VW-1:0] c_CNT_MAX     = c_VW'((64'd1 << WIDTH) - 64'd1);
  localparam logic [c_VW-1:0] c_TOP_BOUNCE  = c_VW'(WIDTH - 1);
  localparam logic [c_VW-1:0] c_TOP_BAR     = c_VW'(WIDTH);
  localparam logic [c_VW-1:0] c_TOP_BREATHE = c_VW'((64'd1 << PWM_BITS) - 64'd1);

  logic                r_s1, r_s2, r_s3;
  logic                r_step;
  logic [1:0]          r_mode_act;
  logic [c_VW-1:0]     r_val;
  logic                r_dir;
  logic [PWM_BITS-1:0] r_pwm_cnt;

  logic                w_mode_chg;
  logic [1:0]          w_mode_nxt;
  logic [c_VW-1:0]     w_val_nxt;
  logic                w_dir_nxt;
  logic                w_wrap_nxt;
  logic [c_VW-1:0]     w_top;
  logic [WIDTH:0]      w_shift;
  logic [WIDTH:0]      w_bar;
  logic                w_pwm_on;
  logic [WIDTH-1:0]    w_led_nxt;

  assign w_mode_chg = (mode != r_mode_act);

  always_comb begin
    w_mode_nxt = r_mode_act;
    w_val_nxt  = r_val;
    w_dir_nxt  = r_dir;
    w_wrap_nxt = 1'b0;

    case (r_mode_act)
      c_MODE_BOUNCE: w_top = c_TOP_BOUNCE;
      c_MODE_BAR:    w_top = c_TOP_BAR;
      default:       w_top = c_TOP_BREATHE;
    endcase

    if (w_mode_chg) begin
      // A mode switch restarts the pattern and swallows any coincident step.
      w_mode_nxt = mode;
      w_val_nxt  = '0;
      w_dir_nxt  = c_DIR_UP;
    end else if (r_step && run) begin
      if (r_mode_act == c_MODE_COUNT) begin
        if (r_val == c_CNT_MAX) begin
          w_val_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_val_nxt = r_val + 1'b1;
        end
      end else if (r_dir == c_DIR_UP) begin
        // Triangle walk: turn at the top so each end is held one step only.
        if (r_val == w_top) begin
          w_dir_nxt = c_DIR_DOWN;
          w_val_nxt = w_top - 1'b1;
        end else begin
          w_val_nxt = r_val + 1'b1;
        end
      end else begin
        if (r_val == '0) begin
          w_dir_nxt = c_DIR_UP;
          w_val_nxt = c_VW'(1);
        end else begin
          w_val_nxt = r_val - 1'b1;
          if (r_val == c_VW'(1)) begin
            w_wrap_nxt = 1'b1;
          end
        end
      end
    end
  end

  // LED is built from the next state so it changes on the same edge as val.
  assign w_shift  = (WIDTH + 1)'(1) << w_val_nxt;
  assign w_bar    = w_shift - 1'b1;
  assign w_pwm_on = (c_VW'(r_pwm_cnt) < w_val_nxt);

  always_comb begin
    w_led_nxt = '0;
    case (w_mode_nxt)
      c_MODE_COUNT:  w_led_nxt = w_val_nxt[WIDTH-1:0];
      c_MODE_BOUNCE: w_led_nxt = w_shift[WIDTH-1:0];
      c_MODE_BAR:    w_led_nxt = w_bar[WIDTH-1:0];
      default:       w_led_nxt = {WIDTH{w_pwm_on}};
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_step     <= 1'b0;
      r_mode_act <= c_MODE_COUNT;
      r_val      <= '0;
      r_dir      <= c_DIR_UP;
      r_pwm_cnt  <= '0;
      LED        <= '0;
      wrap       <= 1'b0;
    end else begin
      r_s1       <= step_in;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      // Registered edge detect gives a three-edge step latency.
      r_step     <= r_s2 & ~r_s3;
      r_mode_act <= w_mode_nxt;
      r_val      <= w_val_nxt;
      r_dir      <= w_dir_nxt;
      r_pwm_cnt  <= r_pwm_cnt + 1'b1;
      LED        <= w_led_nxt;
      wrap       <= w_wrap_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_led_pattern_seq                                               |
// | Purpose : Self-checking bench for led_pattern_seq (WIDTH=7, PWM_BITS=8).   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_led_pattern_seq;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         step_in = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         run = 1'b1;
  logic [W-1:0] LED;
  logic         wrap;

  int total = 0;
  int bad = 0;
  int wrap_cnt = 0;

  always #5 clk = ~clk;

  led_pattern_seq #(.WIDTH(W), .PWM_BITS(8)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rstn),
    .step_in   (step_in),
    .mode      (mode),
    .run       (run),
    .LED       (LED),
    .wrap      (wrap)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: position derived from the count of accepted steps since
  // the pattern restarted, with the triangle folded arithmetically.
  function automatic int tri_pos(input int n, input int top);
    int p;
    p = n % (2 * top);
    return (p <= top) ? p : (2 * top - p);
  endfunction

  int           m_mode = 0;
  int           m_n = 0;
  int           m_cyc = 0;
  logic [2:0]   m_hist = '0;
  logic         m_prev = 1'b0;
  logic [W-1:0] exp_led = '0;
  logic         exp_wrap = 1'b0;

  always @(posedge clk) begin
    int  v;
    logic pulse;
    if (!rstn) begin
      m_mode = 0; m_n = 0; m_cyc = 0; m_hist = '0; m_prev = 1'b0;
      exp_led = '0; exp_wrap = 1'b0;
    end else begin
      pulse    = m_hist[2];
      m_hist   = {m_hist[1:0], step_in & ~m_prev};
      m_prev   = step_in;
      exp_wrap = 1'b0;
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode);
        m_n    = 0;
      end else if (pulse && run) begin
        m_n++;
        case (m_mode)
          0:       exp_wrap = (m_n % 128) == 0;
          1:       exp_wrap = (m_n % 12) == 0;
          2:       exp_wrap = (m_n % 14) == 0;
          default: exp_wrap = (m_n % 510) == 0;
        endcase
      end
      case (m_mode)
        0: exp_led = W'(m_n % 128);
        1: exp_led = W'(1 << tri_pos(m_n, 6));
        2: exp_led = W'((1 << tri_pos(m_n, 7)) - 1);
        default: begin
          v = tri_pos(m_n, 255);
          exp_led = ((m_cyc % 256) < v) ? 7'h7F : 7'h00;
        end
      endcase
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    chk("model_led", 32'(LED), 32'(exp_led));
    chk("model_wrap", 32'(wrap), 32'(exp_wrap));
    if (wrap === 1'b1) wrap_cnt++;
  end

  // One step: rise, hold 4 cycles, sample right after the update edge.
  task automatic do_step(output logic [W-1:0] led_at, output logic wrap_at);
    @(negedge clk) step_in = 1'b1;
    repeat (4) @(negedge clk);
    led_at  = LED;
    wrap_at = wrap;
    step_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [W-1:0] bounce_tab [12] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40,
                                    7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h01};
  logic [W-1:0] bar_tab [14] = '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F,
                                 7'h3F, 7'h1F, 7'h0F, 7'h07, 7'h03, 7'h01, 7'h00};

  initial begin
    logic [W-1:0] l;
    logic         wr;
    int           w0;
    int           hc [W];
    int           n40;

    // Reset with step_in toggling.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_led", 32'(LED), 32'h0);
      chk("reset_wrap", 32'(wrap), 32'h0);
      step_in = ~step_in;
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_led", 32'(LED), 32'h0);

    // First step: latency and long high time.
    w0 = wrap_cnt;
    @(negedge clk) step_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("first_step_lat", 32'(LED), (k == 4) ? 32'h1 : 32'h0);
    end
    repeat (1000) @(negedge clk);
    chk("long_high_led", 32'(LED), 32'h1);
    step_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("after_fall_led", 32'(LED), 32'h1);

    // COUNT through the full range.
    for (int i = 2; i <= 128; i++) begin
      do_step(l, wr);
      chk("count_led", 32'(l), 32'(i % 128));
      if (i == 128) chk("count_wrap_at_128", 32'(wr), 32'h1);
    end
    chk("count_wrap_total", 32'(wrap_cnt - w0), 32'h1);

    // BOUNCE.
    @(negedge clk) mode = 2'd1;
    repeat (2) @(negedge clk);
    chk("bounce_start", 32'(LED), 32'h01);
    w0 = wrap_cnt;
    n40 = 0;
    for (int i = 0; i < 12; i++) begin
      do_step(l, wr);
      chk("bounce_led", 32'(l), 32'(bounce_tab[i]));
      if (l == 7'h40) n40++;
      if (i == 11) chk("bounce_wrap_at_12", 32'(wr), 32'h1);
    end
    chk("bounce_top_once", 32'(n40), 32'h1);
    chk("bounce_wrap_total", 32'(wrap_cnt - w0), 32'h1);

    // BAR.
    @(negedge clk) mode = 2'd2;
    repeat (2) @(negedge clk);
    chk("bar_start", 32'(LED), 32'h00);
    w0 = wrap_cnt;
    for (int i = 0; i < 14; i++) begin
      do_step(l, wr);
      chk("bar_led", 32'(l), 32'(bar_tab[i]));
      if (i == 13) chk("bar_wrap_at_14", 32'(wr), 32'h1);
    end
    chk("bar_wrap_total", 32'(wrap_cnt - w0), 32'h1);

    // BREATHE: duty 0 stays dark, duty 128 gives half brightness.
    @(negedge clk) mode = 2'd3;
    repeat (2) @(negedge clk);
    for (int b = 0; b < W; b++) hc[b] = 0;
    for (int c = 0; c < 512; c++) begin
      @(negedge clk);
      for (int b = 0; b < W; b++) if (LED[b]) hc[b]++;
    end
    for (int b = 0; b < W; b++) chk("breathe_duty0_high", 32'(hc[b]), 32'h0);
    for (int i = 0; i < 128; i++) do_step(l, wr);
    for (int b = 0; b < W; b++) hc[b] = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      for (int b = 0; b < W; b++) if (LED[b]) hc[b]++;
    end
    for (int b = 0; b < W; b++) chk("breathe_duty128_high", 32'(hc[b]), 32'd128);

    // Mode change coinciding with a step: step is dropped.
    @(negedge clk) mode = 2'd0;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      do_step(l, wr);
      chk("prio_count_led", 32'(l), 32'(i));
    end
    w0 = wrap_cnt;
    @(negedge clk) step_in = 1'b1;
    repeat (3) @(negedge clk);
    mode = 2'd2;
    @(negedge clk);
    chk("prio_led", 32'(LED), 32'h0);
    chk("prio_wrap", 32'(wrap), 32'h0);
    step_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("prio_led_hold", 32'(LED), 32'h0);

    // Frozen pattern.
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_step(l, wr);
      chk("run0_led", 32'(l), 32'h0);
    end
    run = 1'b1;
    do_step(l, wr);
    chk("run1_led", 32'(l), 32'h01);
    chk("prio_no_wrap", 32'(wrap_cnt - w0), 32'h0);

    // Reset mid-pattern.
    do_step(l, wr);
    chk("pre_reset_led", 32'(l), 32'h03);
    @(negedge clk) rstn = 1'b0;
    @(negedge clk);
    chk("mid_reset_led", 32'(LED), 32'h0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_mid_reset_led", 32'(LED), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
